// File: rtl/ubrcs_pkg.sv
// Shared types and constants for the sequential block-wise subtractor (ubrcs_sub_seq).
package ubrcs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BLK_W = 4;

  function automatic int nblk(input int y_w);
    return y_w / BLK_W;
  endfunction

endpackage

// File: rtl/ubrcs_cla4.sv
// Purely combinational 4-bit carry look-ahead slice, shared by every block pass.
module ubrcs_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       gblk,
  output logic       pblk
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign gblk = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pblk = &p;
  assign cout = gblk | (pblk & cin);
  assign s    = p ^ c;

endmodule

// File: rtl/ubrcs_sub_seq.sv
// Sequential subtractor d = y - x, one 4-bit look-ahead block per cycle.
// Define UBRCS_ABS_EN to add the NEG pass that turns a negative result into its magnitude.
module ubrcs_sub_seq
  import ubrcs_pkg::*;
#(
  parameter int X_W = 8,
  parameter int Y_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Y_W:0]   d,
  output logic [1:0]     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid, once raised, holds its payload stable until that edge.

  localparam int NBLK = nblk(Y_W);
  localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  state_t         state;
  logic [Y_W-1:0] xr;
  logic [Y_W-1:0] yr;
  logic [KW-1:0]  k;
  logic           c;

  logic [3:0] a_blk;
  logic [3:0] b_blk;
  logic [3:0] s_blk;
  logic       cout;
  logic       gblk;
  logic       pblk;
  logic       last;

  assign dbg_state = state;
  assign last      = (k == KW'(NBLK - 1));

  // CALC feeds y + ~x; NEG feeds ~d + 0 so the same slice forms the two's complement.
  always_comb begin
    a_blk = yr[k*BLK_W +: BLK_W];
    b_blk = ~xr[k*BLK_W +: BLK_W];
    if (state == NEG) begin
      a_blk = ~d[k*BLK_W +: BLK_W];
      b_blk = '0;
    end
  end

  ubrcs_cla4 u_cla4 (
    .a    (a_blk),
    .b    (b_blk),
    .cin  (c),
    .s    (s_blk),
    .cout (cout),
    .gblk (gblk),
    .pblk (pblk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      xr        <= '0;
      yr        <= '0;
      d         <= '0;
      k         <= '0;
      c         <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr       <= Y_W'(x);
            yr       <= y;
            k        <= '0;
            c        <= 1'b1;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          d[k*BLK_W +: BLK_W] <= s_blk;
          c <= cout;
          k <= k + 1'b1;
          if (last) begin
            // No carry out of the top block means y < x.
            d[Y_W] <= ~(gblk | (pblk & c));
`ifdef UBRCS_ABS_EN
            if (!cout) begin
              k     <= '0;
              c     <= 1'b1;
              state <= NEG;
            end else begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
`else
            out_valid <= 1'b1;
            state     <= DONE;
`endif
          end
        end
`ifdef UBRCS_ABS_EN
        NEG: begin
          d[k*BLK_W +: BLK_W] <= s_blk;
          c <= cout;
          k <= k + 1'b1;
          if (last) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ubrcs_sub_seq.sv
// Self-checking bench for ubrcs_sub_seq: directed steps plus random operands against a reference model.
module tb_ubrcs_sub_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [11:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] d;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  ubrcs_sub_seq #(.X_W(8), .Y_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: borrow when x > y; modular difference, or magnitude with ABS enabled.
  function automatic logic [12:0] model(input logic [11:0] yy, input logic [7:0] xx);
    int unsigned yi;
    int unsigned xi;
    logic        borrow;
    logic [11:0] mag;
    yi     = yy;
    xi     = xx;
    borrow = (xi > yi);
`ifdef UBRCS_ABS_EN
    mag = borrow ? 12'(xi - yi) : 12'(yi - xi);
`else
    mag = 12'(yi - xi);
`endif
    return {borrow, mag};
  endfunction

  function automatic int model_lat(input logic [11:0] yy, input logic [7:0] xx);
`ifdef UBRCS_ABS_EN
    return (32'(xx) > 32'(yy)) ? 6 : 3;
`else
    return 3;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Driver: one full transaction with an optional out_ready stall once the result is up.
  task automatic do_op(input logic [11:0] yy, input logic [7:0] xx, input int hold);
    int          cnt;
    logic [12:0] expd;
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    y        = yy;
    x        = xx;
    in_valid = 1'b1;
    exp_q.push_back(model(yy, xx));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_ready", {31'd0, in_ready}, 32'd0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", cnt, model_lat(yy, xx));
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      expd = 'x;
    end else begin
      expd = exp_q.pop_front();
    end
    check("result", {19'd0, d}, {19'd0, expd});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_d", {19'd0, d}, {19'd0, expd});
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_ready", {31'd0, in_ready}, 32'd1);
    check("post_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int          got;
    logic [12:0] expd;
    logic [11:0] ry;
    logic [7:0]  rx;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_d", {19'd0, d}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_op(12'h123, 8'h23, 0);
    check("d_0x123_0x23", {19'd0, d}, 32'h0100);
    do_op(12'h005, 8'h07, 0);
    do_op(12'hFFF, 8'hFF, 0);
    do_op(12'h080, 8'h80, 0);
    do_op(12'h000, 8'hFF, 0);
    do_op(12'h0FF, 8'hFF, 0);
    do_op(12'h234, 8'h56, 5);

    // Reset during the second CALC cycle drops the operation
    @(negedge clk);
    y        = 12'h777;
    x        = 8'h11;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_d", {19'd0, d}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_op(12'h010, 8'h01, 0);
    check("after_rst_d", {19'd0, d}, 32'h000F);

    // Random operands with random consumer stalls
    for (int i = 0; i < 12; i++) begin
      ry = 12'($urandom_range(0, 4095));
      rx = 8'($urandom_range(0, 255));
      if (i % 3 == 0) ry = 12'($urandom_range(0, 255));
      do_op(ry, rx, $urandom_range(0, 3));
    end

    // Streaming: in_valid held high with operands changing every cycle
    got       = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL stream_extra observed=%0h expected=none", d);
        end else begin
          expd = exp_q.pop_front();
          check("stream_d", {19'd0, d}, {19'd0, expd});
          got++;
        end
      end
      y        = 12'($urandom_range(0, 4095));
      x        = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      if (in_ready) exp_q.push_back(model(y, x));
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
      if (out_valid) begin
        expd = exp_q.pop_front();
        check("stream_d", {19'd0, d}, {19'd0, expd});
        got++;
      end
      @(negedge clk);
    end
    check("stream_drained", exp_q.size(), 32'd0);
    check("stream_some", {31'd0, (got >= 5)}, 32'd1);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ubrcs_sub_seq.md
# ubrcs_sub_seq

Sequential unsigned subtractor that computes D = Y − X for an 8-bit X and a 12-bit Y. It is the inverse-direction companion of the team's 8+12-bit ripple-block carry look-ahead adder. The datapath is the same 4-bit carry look-ahead slice, reused once per block: one 4-bit block per cycle, with a registered block-to-block carry ripple between cycles. The block sits behind a valid/ready operand port and a valid/ready result port, so it can be placed in multi-cycle arithmetic paths where area matters more than latency.

## Interface
- X_W, default 8: X operand width; must satisfy X_W ≤ Y_W. X is zero-extended to Y_W internally.
- Y_W, default 12: Y operand width; must be a multiple of 4. NBLK = Y_W/4, which is 3 at default.
- clk  input  1  the only clock; everything is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands are presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- x  input  X_W  subtrahend.
- y  input  Y_W  minuend.
- out_valid  output  1  result is valid; held until it is taken.
- out_ready  input  1  consumer takes the result.
- d  output  Y_W+1  d[Y_W] is the borrow/sign bit; d[Y_W-1:0] is the difference.

## Operation
- States: IDLE, CALC, NEG (present only with the config macro), DONE.
- IDLE: in_ready = 1. When in_valid && in_ready, the block registers zero-extended x and y, clears the block index k to 0, sets the carry register c to 1 (two's-complement carry-in), and moves to CALC.
- CALC, one block per cycle:
  - The slice gets A = y[4k+3:4k], B = ~x[4k+3:4k], cin = c.
  - Per bit: G = A&B and P = A^B. S[i] = P[i]^C[i], with in-block look-ahead carries C[1..3] and block carry-out Gblk | (Pblk & cin).
  - The block result is written into the d register, c ← carry-out, k ← k+1.
  - After block NBLK−1: d[Y_W] ← ~carry-out (1 exactly when x > y).
  - Next state is NEG if the macro is defined and borrow = 1. Otherwise next state is DONE.
- NEG: computes the two's-complement magnitude ~d + 1, one block per cycle, through the same slice.
  - Slice inputs: A = ~d block, B = 0, initial cin = 1. k restarts at 0.
  - d[Y_W] is left unchanged. After the last block the state moves to DONE.
- DONE: out_valid = 1, and d is held stable. When out_valid && out_ready, the state returns to IDLE.
- Arithmetic: without the macro, d[Y_W-1:0] = (y − x) mod 2^Y_W. The carry out of the final NEG block is discarded.
- Reset, at any time including mid-CALC or mid-NEG:
  - State goes to IDLE, d = 0, c = 0, k = 0, out_valid = 0.
  - in_ready reads 1 as soon as the state is IDLE.
  - Any partial operation is dropped.

## Timing
- Let T0 be the rising edge at which the operands are accepted.
- CALC blocks commit on edges T1..T_NBLK. out_valid rises after T_NBLK, which is T3 at default (latency 3).
- With the macro and borrow = 1, the NEG blocks commit on T4..T6 and out_valid rises after T6 (latency 6).
- in_ready = 0 from the cycle after T0 until the cycle after the output handshake. Accept and deliver never overlap, so the minimum initiation interval is NBLK+2 cycles.
- out_ready held low: state stays DONE, and d and out_valid are unchanged for any number of cycles.
- in_valid while in_ready = 0 is ignored. Operands are not sampled and no error is flagged.
- out_ready while out_valid = 0 has no effect.

## Configuration
- UBRCS_ABS_EN defined: the NEG state exists. d[Y_W-1:0] = |y − x| and d[Y_W] = sign (1 when x > y). Latency is data-dependent: NBLK cycles, or 2·NBLK cycles when x > y.
- UBRCS_ABS_EN undefined: there is no NEG state. d is the modular difference plus borrow, and latency is always NBLK.

## Structure
- Package ubrcs_pkg holds:
  - the state enum (IDLE, CALC, NEG, DONE);
  - BLK_W = 4;
  - a function computing NBLK from Y_W.
- Sub-module ubrcs_cla4: a purely combinational 4-bit look-ahead slice.
  - Inputs: A[3:0], B[3:0], cin.
  - Outputs: S[3:0], cout, Gblk, Pblk.
  - It is instantiated once and shared by CALC and NEG.
- Top level holds the FSM, the operand registers, k, c and the d register.

## Test plan
- y=0x123, x=0x23 → d=0x0100, d[12]=0, out_valid exactly 3 cycles after accept.
- y=0x005, x=0x07:
  - without macro → d[11:0]=0xFFE, d[12]=1, after 3 cycles;
  - with macro → d[11:0]=0x002, d[12]=1, after 6 cycles.
- y=0xFFF, x=0xFF → d[11:0]=0xF00, borrow 0. Also y=x=0x080 → d=0, borrow 0.
- Result reached with out_ready low for 5 cycles → d, out_valid=1 and in_ready=0 stable throughout. Raising out_ready gives in_ready=1 on the next cycle.
- rst pulsed during the second CALC cycle → out_valid=0 and d=0 immediately, in_ready=1. A fresh operation afterwards (y=0x010, x=0x01) → d=0x00F.
- in_valid held high continuously with changing operands → only the operands present at each IDLE handshake are used. Results match those operand pairs in order.
